// File: rtl/elevator_ctrl.sv
// rtl/elevator_ctrl.sv - single-car elevator controller: request latch plus IDLE/MOVE/DOOR sequencer
// Decisions use pending|call so a call seen this cycle is acted on at the coming edge.
module elevator_ctrl #(
  parameter int NFLOORS    = 8,
  parameter int MOVE_TICKS = 4,
  parameter int DOOR_TICKS = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [NFLOORS-1:0] call,
  output logic [2:0]         floor,
  output logic               stop,
  output logic               head,
  output logic               door_open,
  output logic [NFLOORS-1:0] pending
);

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

  state_t             state, state_n;
  logic [2:0]         floor_n;
  logic               head_n;
  logic [7:0]         mcnt, mcnt_n, dcnt, dcnt_n;
  logic [NFLOORS-1:0] req, pending_n;
  logic               above, below;

  function automatic logic hit(input logic [NFLOORS-1:0] r, input logic [2:0] f);
    hit = 1'b0;
    for (int i = 0; i < NFLOORS; i++)
      if (r[i] && i == int'(f)) hit = 1'b1;
  endfunction

  // Any request strictly beyond floor f in the given direction.
  function automatic logic beyond(input logic [NFLOORS-1:0] r, input logic [2:0] f,
                                  input logic up);
    beyond = 1'b0;
    for (int i = 0; i < NFLOORS; i++)
      if (r[i] && (up ? (i > int'(f)) : (i < int'(f)))) beyond = 1'b1;
  endfunction

  always_comb begin
    state_n = state;
    floor_n = floor;
    head_n  = head;
    mcnt_n  = mcnt;
    dcnt_n  = dcnt;
    req     = pending | call;
    above   = beyond(req, floor, 1'b1);
    below   = beyond(req, floor, 1'b0);

    case (state)
      IDLE: begin
        if (hit(req, floor)) begin
          state_n = DOOR;
          dcnt_n  = 8'd0;
        end else if (above && (head || !below)) begin
          head_n  = 1'b1;
          state_n = MOVE;
          mcnt_n  = 8'd0;
        end else if (below) begin
          head_n  = 1'b0;
          state_n = MOVE;
          mcnt_n  = 8'd0;
        end
      end
      MOVE: begin
        if (tick) begin
          if (mcnt == 8'(MOVE_TICKS - 1)) begin
            mcnt_n = 8'd0;
            if (head)
              floor_n = (floor == 3'(NFLOORS - 1)) ? floor : floor + 3'd1;
            else
              floor_n = (floor == 3'd0) ? floor : floor - 3'd1;
            if (hit(req, floor_n)) begin
              state_n = DOOR;
              dcnt_n  = 8'd0;
            end else if (!beyond(req, floor_n, head)) begin
              state_n = IDLE;
            end
          end else begin
            mcnt_n = mcnt + 8'd1;
          end
        end
      end
      DOOR: begin
        if (tick) begin
          if (dcnt == 8'(DOOR_TICKS - 1)) begin
            dcnt_n  = 8'd0;
            state_n = IDLE;
          end else begin
            dcnt_n = dcnt + 8'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // The open floor absorbs calls on the entry edge and on every edge while open.
    pending_n = req;
    if (state == DOOR || state_n == DOOR)
      for (int i = 0; i < NFLOORS; i++)
        if (i == int'(floor_n)) pending_n[i] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      floor   <= 3'd0;
      head    <= 1'b1;
      mcnt    <= 8'd0;
      dcnt    <= 8'd0;
      pending <= '0;
    end else begin
      state   <= state_n;
      floor   <= floor_n;
      head    <= head_n;
      mcnt    <= mcnt_n;
      dcnt    <= dcnt_n;
      pending <= pending_n;
    end
  end

  assign stop      = (state != MOVE);
  assign door_open = (state == DOOR);

endmodule

// File: tb/tb_elevator_ctrl.sv
// tb/tb_elevator_ctrl.sv - directed and randomized bench for elevator_ctrl against a floor/mode model
module tb_elevator_ctrl;
  localparam int NF = 8;
  localparam int MT = 4;
  localparam int DT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic [NF-1:0] call;
  logic [2:0]    floor;
  logic          stop, head, door_open;
  logic [NF-1:0] pending;

  int checks   = 0;
  int failures = 0;

  elevator_ctrl #(.NFLOORS(NF), .MOVE_TICKS(MT), .DOOR_TICKS(DT)) dut (
    .clk(clk), .rst(rst), .tick(tick), .call(call), .floor(floor),
    .stop(stop), .head(head), .door_open(door_open), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: car mode, floor, heading, outstanding floor set, ticks left in the current activity.
  string m_mode;
  int    m_floor;
  bit    m_up;
  bit    m_req[NF];
  int    m_left;

  function automatic void m_reset();
    m_mode  = "idle";
    m_floor = 0;
    m_up    = 1'b1;
    m_left  = 0;
    for (int i = 0; i < NF; i++) m_req[i] = 1'b0;
  endfunction

  function automatic bit m_any(input int lo, input int hi);
    for (int i = lo; i <= hi; i++)
      if (i >= 0 && i < NF && m_req[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_step(input logic [NF-1:0] c, input bit t);
    bit was_door, up_w, dn_w;
    was_door = (m_mode == "door");
    for (int i = 0; i < NF; i++) if (c[i]) m_req[i] = 1'b1;
    up_w = m_any(m_floor + 1, NF - 1);
    dn_w = m_any(0, m_floor - 1);
    if (m_mode == "idle") begin
      if (m_req[m_floor]) begin
        m_mode = "door"; m_left = DT;
      end else if (up_w && (m_up || !dn_w)) begin
        m_up = 1'b1; m_mode = "move"; m_left = MT;
      end else if (dn_w) begin
        m_up = 1'b0; m_mode = "move"; m_left = MT;
      end
    end else if (m_mode == "move") begin
      if (t) begin
        m_left--;
        if (m_left == 0) begin
          m_floor = m_up ? m_floor + 1 : m_floor - 1;
          if (m_req[m_floor]) begin
            m_mode = "door"; m_left = DT;
          end else if (m_up ? m_any(m_floor + 1, NF - 1) : m_any(0, m_floor - 1)) begin
            m_left = MT;
          end else begin
            m_mode = "idle";
          end
        end
      end
    end else begin
      if (t) begin
        m_left--;
        if (m_left == 0) m_mode = "idle";
      end
    end
    if (was_door || m_mode == "door") m_req[m_floor] = 1'b0;
  endfunction

  function automatic logic [NF-1:0] m_pend();
    logic [NF-1:0] p;
    for (int i = 0; i < NF; i++) p[i] = m_req[i];
    return p;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".floor"}, 32'(floor), 32'(m_floor));
    check({tag, ".stop"}, 32'(stop), 32'(m_mode != "move"));
    check({tag, ".head"}, 32'(head), 32'(m_up));
    check({tag, ".door"}, 32'(door_open), 32'(m_mode == "door"));
    check({tag, ".pending"}, 32'(pending), 32'(m_pend()));
  endtask

  task automatic cycle(input string tag, input logic [NF-1:0] c, input bit t);
    @(negedge clk);
    call = c;
    tick = t;
    m_step(c, t);
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic wait_door(input string tag, input int budget);
    int n;
    n = 0;
    while (!door_open && n < budget) begin
      cycle(tag, '0, 1'b1);
      n++;
    end
    if (!door_open) check({tag, ".timeout"}, 32'(n), 32'(budget + 1));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (!(stop && !door_open) && n < budget) begin
      cycle(tag, '0, 1'b1);
      n++;
    end
    if (!(stop && !door_open)) check({tag, ".timeout"}, 32'(n), 32'(budget + 1));
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    m_reset();
    check({tag, ".floor"}, 32'(floor), 32'd0);
    check({tag, ".stop"}, 32'(stop), 32'd1);
    check({tag, ".head"}, 32'(head), 32'd1);
    check({tag, ".door"}, 32'(door_open), 32'd0);
    check({tag, ".pending"}, 32'(pending), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    tick = 1'b1;
    call = '1;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.pending", 32'(pending), 32'd0);
    compare_all("rst");
    @(negedge clk);
    rst  = 1'b0;
    call = '0;

    // Call at the idle floor opens the door without moving.
    cycle("r28", 8'h01, 1'b1);
    check("r28.door_now", 32'(door_open), 32'd1);
    check("r28.floor0", 32'(floor), 32'd0);
    repeat (2) cycle("r28", '0, 1'b1);
    check("r28.door_held", 32'(door_open), 32'd1);
    cycle("r28", '0, 1'b1);
    check("r28.door_closed", 32'(door_open), 32'd0);

    cycle("r27", 8'h08, 1'b1);
    check("r27.moving", 32'(stop), 32'd0);
    check("r27.up", 32'(head), 32'd1);
    repeat (4) cycle("r27", '0, 1'b1);
    check("r27.floor1", 32'(floor), 32'd1);
    repeat (8) cycle("r27", '0, 1'b1);
    check("r27.floor3", 32'(floor), 32'd3);
    check("r27.door3", 32'(door_open), 32'd1);
    check("r27.pend3", 32'(pending[3]), 32'd0);
    repeat (3) cycle("r27", '0, 1'b1);
    check("r27.idle", 32'(stop && !door_open), 32'd1);

    cycle("r29", 8'b0010_0010, 1'b1);
    wait_door("r29", 40);
    check("r29.first", 32'(floor), 32'd5);
    wait_idle("r29", 20);
    wait_door("r29", 60);
    check("r29.second", 32'(floor), 32'd1);
    check("r29.down", 32'(head), 32'd0);
    wait_idle("r29", 20);

    cycle("r30", 8'h01, 1'b1);
    wait_door("r30", 20);
    wait_idle("r30", 20);
    cycle("r30", 8'h40, 1'b1);
    for (int n = 0; n < 20 && floor != 3'd1; n++) cycle("r30", '0, 1'b1);
    cycle("r30", 8'h04, 1'b1);
    wait_door("r30", 20);
    check("r30.stop2", 32'(floor), 32'd2);
    wait_idle("r30", 20);
    wait_door("r30", 40);
    check("r30.reach6", 32'(floor), 32'd6);
    wait_idle("r30", 20);

    cycle("r31", 8'h01, 1'b1);
    repeat (6) cycle("r31", '0, 1'b1);
    async_reset("r31");

    cycle("r32", 8'h10, 1'b1);
    repeat (2) cycle("r32", '0, 1'b1);
    repeat (10) cycle("r32", '0, 1'b0);
    check("r32.frozen", 32'(floor), 32'd0);
    cycle("r32", '0, 1'b1);
    check("r32.not_yet", 32'(floor), 32'd0);
    cycle("r32", '0, 1'b1);
    check("r32.moved", 32'(floor), 32'd1);

    for (int n = 0; n < 3000; n++) begin
      logic [NF-1:0] c;
      c = '0;
      if ($urandom_range(0, 5) == 0) c[$urandom_range(0, NF - 1)] = 1'b1;
      if ($urandom_range(0, 40) == 0) c = NF'($urandom);
      if ($urandom_range(0, 700) == 0) async_reset("rand.rst");
      else cycle("rand", c, ($urandom_range(0, 4) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
